// File: rtl/csr_status_pkg.sv
// Shared definitions for the CSR status block: address map constants,
// region enumeration and the address decode helper.
package csr_status_pkg;

  typedef logic [7:0] addr_t;

  localparam addr_t CTRL_BASE  = 8'h00;
  localparam addr_t MASK_BASE  = 8'h20;
  localparam addr_t STAT_BASE  = 8'h40;
  localparam addr_t CYCLE_ADDR = 8'h7E;
  localparam addr_t ID_ADDR    = 8'h7F;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_MASK,
    REG_STAT,
    REG_CYCLE,
    REG_ID,
    REG_NONE
  } region_e;

  typedef struct packed {
    region_e    region;
    logic [3:0] index;
  } decode_t;

  // Map an address to its region and word index. Words beyond the
  // configured counts fall into REG_NONE.
  function automatic decode_t decode(addr_t addr, int n_ctrl, int n_stat);
    decode_t d;
    int      off_ctrl;
    int      off_mask;
    int      off_stat;
    off_ctrl = int'(addr) - int'(CTRL_BASE);
    off_mask = int'(addr) - int'(MASK_BASE);
    off_stat = int'(addr) - int'(STAT_BASE);
    d.region = REG_NONE;
    d.index  = '0;
    if (addr == CYCLE_ADDR) begin
      d.region = REG_CYCLE;
    end else if (addr == ID_ADDR) begin
      d.region = REG_ID;
    end else if (off_ctrl >= 0 && off_ctrl < n_ctrl) begin
      d.region = REG_CTRL;
      d.index  = off_ctrl[3:0];
    end else if (off_mask >= 0 && off_mask < n_stat) begin
      d.region = REG_MASK;
      d.index  = off_mask[3:0];
    end else if (off_stat >= 0 && off_stat < n_stat) begin
      d.region = REG_STAT;
      d.index  = off_stat[3:0];
    end
    return d;
  endfunction

endpackage

// File: rtl/csr_status_block_if.sv
// Register-access bus between the command parser (master) and the CSR
// status block (slave): write/read strobes plus the read response.
interface csr_status_block_if #(
  parameter int WIDTH = 32
);
  import csr_status_pkg::*;

  logic             i_w_en;
  addr_t            i_w_addr;
  logic [WIDTH-1:0] i_w_data;
  logic             i_r_en;
  addr_t            i_r_addr;
  logic [WIDTH-1:0] o_r_data;
  logic             o_r_valid;

  modport master (
    output i_w_en, i_w_addr, i_w_data, i_r_en, i_r_addr,
    input  o_r_data, o_r_valid
  );

  modport slave (
    input  i_w_en, i_w_addr, i_w_data, i_r_en, i_r_addr,
    output o_r_data, o_r_valid
  );

endinterface

// File: rtl/sticky_status_word.sv
// One sticky status word: bits latch on set, clear on write-1-to-clear
// or on a whole-word clear request; a coincident set always wins.
module sticky_status_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] w1c,
  input  logic             clear_all,
  output logic [WIDTH-1:0] value
);

  // Sticky update: clear first, then OR in new events so set wins.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (i_reset) begin
      value <= '0;
    end else if (clear_all) begin
      value <= set;
    end else begin
      value <= (value & ~w1c) | set;
    end
  end

endmodule

// File: rtl/csr_status_block.sv
// CSR status block: control words, interrupt masks, sticky W1C status
// words, a free-running cycle counter and a constant ID word, accessed
// through single-cycle write strobes and 1-cycle-latency reads.
// Optional feature macro: CSR_STATUS_CLEAR_ON_READ_EN (reading a STAT word
// clears it at the following edge).
module csr_status_block
  import csr_status_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               N_CTRL   = 4,
  parameter int               N_STAT   = 4,
  parameter logic [WIDTH-1:0] ID_VALUE = 32'hC5B1_0001
) (
  input  logic                    clk,
  input  logic                    i_reset,
  csr_status_block_if.slave       bus,
  output logic [N_CTRL*WIDTH-1:0] o_ctrl,
  output logic [N_CTRL-1:0]       o_ctrl_wr,
  input  logic [N_STAT*WIDTH-1:0] i_stat_set,
  output logic                    o_irq
);

  logic [N_CTRL-1:0][WIDTH-1:0] ctrl_q;
  logic [N_STAT-1:0][WIDTH-1:0] mask_q;
  logic [N_STAT-1:0][WIDTH-1:0] stat_q;
  logic [WIDTH-1:0]             cycle_q;
  logic [WIDTH-1:0]             rd_word;
  logic [WIDTH-1:0]             r_data_q;
  logic                         r_valid_q;

  decode_t wr_dec;
  decode_t rd_dec;

  assign wr_dec = decode(bus.i_w_addr, N_CTRL, N_STAT);
  assign rd_dec = decode(bus.i_r_addr, N_CTRL, N_STAT);

  assign o_ctrl        = ctrl_q;
  assign bus.o_r_data  = r_data_q;
  assign bus.o_r_valid = r_valid_q;

  // Control and mask writes; o_ctrl_wr pulses for the written word.
  always_ff @(posedge clk) begin
    // NOTE: the register file is reset explicitly because its reset
    // contents are software-visible; this is a handful of flops, not RAM.
    if (i_reset) begin
      ctrl_q    <= '0;
      mask_q    <= '0;
      o_ctrl_wr <= '0;
    end else begin
      o_ctrl_wr <= '0;
      for (int k = 0; k < N_CTRL; k++) begin
        if (bus.i_w_en && wr_dec.region == REG_CTRL && wr_dec.index == 4'(k)) begin
          ctrl_q[k]    <= bus.i_w_data;
          o_ctrl_wr[k] <= 1'b1;
        end
      end
      for (int k = 0; k < N_STAT; k++) begin
        if (bus.i_w_en && wr_dec.region == REG_MASK && wr_dec.index == 4'(k)) begin
          mask_q[k] <= bus.i_w_data;
        end
      end
    end
  end

  // Sticky status words, one per STAT address.
  for (genvar k = 0; k < N_STAT; k++) begin : g_stat
    logic [WIDTH-1:0] w1c;
    logic             clear_all;

    assign w1c = (bus.i_w_en && wr_dec.region == REG_STAT && wr_dec.index == 4'(k))
                 ? bus.i_w_data : '0;
`ifdef CSR_STATUS_CLEAR_ON_READ_EN
    assign clear_all = bus.i_r_en && rd_dec.region == REG_STAT && rd_dec.index == 4'(k);
`else
    assign clear_all = 1'b0;
`endif

    sticky_status_word #(.WIDTH(WIDTH)) u_word (
      .clk       (clk),
      .i_reset   (i_reset),
      .set       (i_stat_set[k*WIDTH +: WIDTH]),
      .w1c       (w1c),
      .clear_all (clear_all),
      .value     (stat_q[k])
    );
  end

  // Free-running cycle counter; wraps naturally, cleared only by reset.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
    end
  end

  // Read mux over pre-write state, so a same-cycle write is not visible.
  always_comb begin
    // NOTE: default assignment first keeps every path assigned and
    // prevents a latch on rd_word.
    rd_word = '0;
    case (rd_dec.region)
      REG_CTRL: begin
        for (int k = 0; k < N_CTRL; k++) begin
          if (rd_dec.index == 4'(k)) rd_word = ctrl_q[k];
        end
      end
      REG_MASK: begin
        for (int k = 0; k < N_STAT; k++) begin
          if (rd_dec.index == 4'(k)) rd_word = mask_q[k];
        end
      end
      REG_STAT: begin
        for (int k = 0; k < N_STAT; k++) begin
          if (rd_dec.index == 4'(k)) rd_word = stat_q[k];
        end
      end
      REG_CYCLE: rd_word = cycle_q;
      REG_ID:    rd_word = ID_VALUE;
      default:   rd_word = '0;
    endcase
  end

  // Read response register: valid pulses for one cycle, data holds.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= bus.i_r_en;
      if (bus.i_r_en) r_data_q <= rd_word;
    end
  end

  // Interrupt: registered OR of masked status across all words.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |(stat_q & mask_q);
    end
  end

endmodule

// File: tb/tb_csr_status_block.sv
// Directed self-checking bench for csr_status_block.
module tb_csr_status_block;
  import csr_status_pkg::*;

  localparam int               WIDTH  = 32;
  localparam int               N_CTRL = 4;
  localparam int               N_STAT = 4;
  localparam logic [WIDTH-1:0] ID     = 32'hC5B1_0001;

`ifdef CSR_STATUS_CLEAR_ON_READ_EN
  localparam logic [WIDTH-1:0] STAT0_SECOND_READ = 32'h0;
`else
  localparam logic [WIDTH-1:0] STAT0_SECOND_READ = 32'h3;
`endif

  logic                    clk;
  logic                    i_reset;
  logic [N_CTRL*WIDTH-1:0] o_ctrl;
  logic [N_CTRL-1:0]       o_ctrl_wr;
  logic [N_STAT*WIDTH-1:0] i_stat_set;
  logic                    o_irq;

  int n_cmp  = 0;
  int n_fail = 0;

  csr_status_block_if #(.WIDTH(WIDTH)) bus ();

  csr_status_block #(
    .WIDTH    (WIDTH),
    .N_CTRL   (N_CTRL),
    .N_STAT   (N_STAT),
    .ID_VALUE (ID)
  ) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .bus        (bus),
    .o_ctrl     (o_ctrl),
    .o_ctrl_wr  (o_ctrl_wr),
    .i_stat_set (i_stat_set),
    .o_irq      (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                       input logic [WIDTH-1:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic write_reg(input addr_t addr, input logic [WIDTH-1:0] data);
    bus.i_w_en   = 1'b1;
    bus.i_w_addr = addr;
    bus.i_w_data = data;
    tick();
    bus.i_w_en   = 1'b0;
  endtask

  task automatic read_check(input string tag, input addr_t addr,
                            input logic [WIDTH-1:0] expected);
    bus.i_r_en   = 1'b1;
    bus.i_r_addr = addr;
    tick();
    bus.i_r_en   = 1'b0;
    check({tag, "_valid"}, {31'b0, bus.o_r_valid}, 1);
    check(tag, bus.o_r_data, expected);
  endtask

  task automatic pulse_stat(input int word, input logic [WIDTH-1:0] bits);
    i_stat_set[word*WIDTH +: WIDTH] = bits;
    tick();
    i_stat_set = '0;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_stat_set   = '0;
    bus.i_w_en   = 1'b0;
    bus.i_w_addr = '0;
    bus.i_w_data = '0;
    bus.i_r_en   = 1'b0;
    bus.i_r_addr = '0;
    tick();
    tick();

    // Reset state
    check("rst_valid",   {31'b0, bus.o_r_valid}, 0);
    check("rst_rdata",   bus.o_r_data, 0);
    check("rst_ctrl_wr", {28'b0, o_ctrl_wr}, 0);
    check("rst_irq",     {31'b0, o_irq}, 0);
    check("rst_ctrl1",   o_ctrl[32 +: 32], 0);

    // Back-to-back reads right after reset: ID, CTRL[0], CYCLE
    i_reset      = 1'b0;
    bus.i_r_en   = 1'b1;
    bus.i_r_addr = 8'h7F;
    tick();
    check("id_valid", {31'b0, bus.o_r_valid}, 1);
    check("id_data",  bus.o_r_data, ID);
    bus.i_r_addr = 8'h00;
    tick();
    check("ctrl0_valid", {31'b0, bus.o_r_valid}, 1);
    check("ctrl0_data",  bus.o_r_data, 0);
    bus.i_r_addr = 8'h7E;
    tick();
    check("cycle_valid", {31'b0, bus.o_r_valid}, 1);
    check("cycle_data",  bus.o_r_data, 2);
    bus.i_r_en = 1'b0;
    tick();
    check("idle_valid", {31'b0, bus.o_r_valid}, 0);
    check("idle_hold",  bus.o_r_data, 2);

    // Control write, pulse and readback
    write_reg(8'h01, 32'hA5A5_0F0F);
    check("ctrl_wr_pulse", {28'b0, o_ctrl_wr}, 32'h2);
    check("ctrl1_out",     o_ctrl[32 +: 32], 32'hA5A5_0F0F);
    read_check("ctrl1_rd", 8'h01, 32'hA5A5_0F0F);
    check("ctrl_wr_clear", {28'b0, o_ctrl_wr}, 0);

    // Same-cycle read and write of one address returns pre-write value
    bus.i_r_en   = 1'b1;
    bus.i_r_addr = 8'h01;
    write_reg(8'h01, 32'h0000_1234);
    bus.i_r_en   = 1'b0;
    check("rw_same_old", bus.o_r_data, 32'hA5A5_0F0F);
    read_check("rw_same_new", 8'h01, 32'h0000_1234);

    // Sticky status, mask and interrupt
    pulse_stat(2, 32'h0000_0011);
    write_reg(8'h22, 32'h0000_0010);
    tick();
    check("irq_set", {31'b0, o_irq}, 1);
    read_check("mask2_rd", 8'h22, 32'h0000_0010);
    read_check("stat2_rd", 8'h42, 32'h0000_0011);
    write_reg(8'h42, 32'h0000_0010);
    tick();
    check("irq_clear", {31'b0, o_irq}, 0);
    read_check("stat2_w1c", 8'h42, 32'h0000_0001);

    // Set wins over a coincident W1C; plain W1C then clears the bit
    i_stat_set[2*WIDTH +: WIDTH] = 32'h1;
    write_reg(8'h42, 32'h1);
    i_stat_set = '0;
    read_check("set_wins", 8'h42, 32'h0000_0001);
    write_reg(8'h42, 32'h1);
    read_check("w1c_only", 8'h42, 32'h0);

    // Interrupt latency: event at N, STAT at N+1, irq at N+2
    pulse_stat(2, 32'h0000_0010);
    check("irq_lat_n1", {31'b0, o_irq}, 0);
    tick();
    check("irq_lat_n2", {31'b0, o_irq}, 1);
    write_reg(8'h42, 32'h0000_0010);
    tick();
    check("irq_lat_off", {31'b0, o_irq}, 0);

    // Four consecutive reads across regions plus an unmapped address
    write_reg(8'h00, 32'hDEAD_BEEF);
    write_reg(8'h20, 32'h0000_00F0);
    pulse_stat(0, 32'h3);
    bus.i_r_en   = 1'b1;
    bus.i_r_addr = 8'h00;
    tick();
    check("burst0_valid", {31'b0, bus.o_r_valid}, 1);
    check("burst0_data",  bus.o_r_data, 32'hDEAD_BEEF);
    bus.i_r_addr = 8'h20;
    tick();
    check("burst1_valid", {31'b0, bus.o_r_valid}, 1);
    check("burst1_data",  bus.o_r_data, 32'h0000_00F0);
    bus.i_r_addr = 8'h40;
    tick();
    check("burst2_valid", {31'b0, bus.o_r_valid}, 1);
    check("burst2_data",  bus.o_r_data, 32'h3);
    bus.i_r_addr = 8'h55;
    tick();
    check("burst3_valid", {31'b0, bus.o_r_valid}, 1);
    check("burst3_data",  bus.o_r_data, 32'h0);
    bus.i_r_en = 1'b0;
    check("irq_masked_out", {31'b0, o_irq}, 0);

    // Clear-on-read behaviour on back-to-back reads of STAT[0]
    pulse_stat(0, 32'h3);
    bus.i_r_en   = 1'b1;
    bus.i_r_addr = 8'h40;
    tick();
    check("cor_first", bus.o_r_data, 32'h3);
    tick();
    check("cor_second_valid", {31'b0, bus.o_r_valid}, 1);
    check("cor_second", bus.o_r_data, STAT0_SECOND_READ);
    bus.i_r_en = 1'b0;

    // Writes to read-only and unmapped addresses are ignored
    write_reg(8'h04, 32'hFFFF_FFFF);
    check("unmapped_no_pulse", {28'b0, o_ctrl_wr}, 0);
    write_reg(8'h7F, 32'h0);
    write_reg(8'h30, 32'hFFFF_FFFF);
    read_check("unmapped_04", 8'h04, 32'h0);
    read_check("id_ro",       8'h7F, ID);
    read_check("ctrl3_clean", 8'h03, 32'h0);
    read_check("unmapped_30", 8'h30, 32'h0);

    // Reset mid-read suppresses the response and clears state
    pulse_stat(2, 32'h0000_0010);
    tick();
    check("irq_pre_rst", {31'b0, o_irq}, 1);
    bus.i_r_en   = 1'b1;
    bus.i_r_addr = 8'h7F;
    i_reset      = 1'b1;
    tick();
    bus.i_r_en   = 1'b0;
    i_reset      = 1'b0;
    check("midrst_valid", {31'b0, bus.o_r_valid}, 0);
    check("midrst_rdata", bus.o_r_data, 0);
    check("midrst_irq",   {31'b0, o_irq}, 0);
    check("midrst_ctrl0", o_ctrl[0 +: 32], 0);
    tick();
    check("post_rst_valid", {31'b0, bus.o_r_valid}, 0);
    read_check("post_rst_stat2", 8'h42, 32'h0);
    read_check("post_rst_ctrl1", 8'h01, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_status_block.md
# csr_status_block

Register-file stage that consumes the command parser's register-access strobes (write enable/address/data, read enable/address) and returns read data with a valid pulse. It provides read/write control words, sticky write-1-to-clear status words fed by hardware events, an interrupt mask, a free-running cycle counter and a constant ID word. It sits directly downstream of `command_parser_uart` and replaces the plain register bank wherever status reporting and an interrupt line are needed.

## Interface
- `WIDTH`, 32: data word width.
- `N_CTRL`, 4: number of control words, 1..16.
- `N_STAT`, 4: number of status words, 1..16.
- `ID_VALUE`, 32'hC5B1_0001: constant returned at the ID address.
- `clk`  in  1  system clock; single clock domain.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_w_en`  in  1  write strobe; one write per asserted cycle.
- `i_w_addr`  in  8  write address.
- `i_w_data`  in  WIDTH  write data.
- `i_r_en`  in  1  read strobe; one read per asserted cycle.
- `i_r_addr`  in  8  read address.
- `o_r_data`  out  WIDTH  read data; valid when `o_r_valid`=1.
- `o_r_valid`  out  1  one-cycle read-response pulse.
- `o_ctrl`  out  N_CTRL*WIDTH  control words; word k at bits [k*WIDTH +: WIDTH].
- `o_ctrl_wr`  out  N_CTRL  one-cycle pulse, bit k set in the cycle after control word k is written.
- `i_stat_set`  in  N_STAT*WIDTH  per-bit event inputs; a 1 sets the corresponding sticky bit.
- `o_irq`  out  1  registered OR over all status words of (status & mask).

## Operation
- Address map:
  - 0x00+k: CTRL[k], read/write.
  - 0x20+k: MASK[k], read/write; per-bit interrupt enable for STAT[k].
  - 0x40+k: STAT[k], sticky; write-1-to-clear.
  - 0x7E: CYCLE counter, read-only.
  - 0x7F: ID, read-only.
- Unmapped reads return 0 with a normal `o_r_valid`. Writes to read-only or unmapped addresses are ignored.
- STAT update each cycle: next = (cur & ~w1c) | set. When set and clear hit the same bit in the same cycle, set wins.
- CYCLE: WIDTH-bit counter, increments every cycle, wraps from all-ones to 0, cleared only by reset.
- Reads and writes are independent and may occur in the same cycle. A read of the address being written in that cycle returns the pre-write value.
- Reset values: CTRL, MASK, STAT, CYCLE all 0; `o_r_data`=0, `o_r_valid`=0, `o_ctrl_wr`=0, `o_irq`=0.

## Timing
- Read latency is exactly 1 cycle: `i_r_en` at cycle N gives `o_r_valid`=1 and data at N+1.
- Back-to-back reads are accepted every cycle with no stall. `o_r_data` holds its last value while `o_r_valid`=0.
- A write at cycle N is visible on `o_ctrl` and to reads issued at N+1. The `o_ctrl_wr` pulse occurs at N+1.
- An event on `i_stat_set` at cycle N appears in STAT at N+1 and on `o_irq` at N+2 (if masked in).
- Reset asserted mid-read suppresses the pending `o_r_valid`. The first cycle after reset deassertion has `o_r_valid`=0.

## Configuration
- `CSR_STATUS_CLEAR_ON_READ_EN`
  - Defined: a read of STAT[k] returns the pre-clear value, then clears the whole word at the next edge. Events arriving in the read cycle are kept (set wins). Write-1-to-clear still works.
  - Undefined: reads have no side effects; only write-1-to-clear clears status bits.

## Structure
- Package `csr_status_pkg`:
  - address base constants `CTRL_BASE`, `MASK_BASE`, `STAT_BASE`, `CYCLE_ADDR`, `ID_ADDR`;
  - typedef `addr_t` (logic [7:0]);
  - enum `region_e` {REG_CTRL, REG_MASK, REG_STAT, REG_CYCLE, REG_ID, REG_NONE} with a decode function.
- Sub-module `sticky_status_word`: one WIDTH-bit sticky register with set, W1C and clear-on-read inputs; instantiated N_STAT times via generate.

## Test plan
- Reset, then read 0x7F, 0x00, 0x7E -> 32'hC5B1_0001, 0, a nonzero CYCLE; each response arrives exactly 1 cycle after its `i_r_en`.
- Write 0x01 = 32'hA5A5_0F0F, read 0x01 in the next cycle -> 32'hA5A5_0F0F; `o_ctrl` word 1 updates and `o_ctrl_wr`=4'b0010 for one cycle.
- Pulse `i_stat_set` word 2 with 0x0000_0011, write MASK[2] (0x22) = 0x10 -> STAT[2] reads 0x11 and `o_irq`=1; write 0x42 = 0x10 -> STAT[2] reads 0x01 and `o_irq`=0.
- Write 0x42 = 0x1 in the same cycle that `i_stat_set` bit 0 of word 2 pulses -> bit 0 remains 1.
- Issue reads of 0x00, 0x20, 0x40, 0x55 on four consecutive cycles -> four consecutive valid pulses with the correct values; 0x55 returns 0.
- With `CSR_STATUS_CLEAR_ON_READ_EN` defined: STAT[0]=0x3, read 0x40 twice -> 0x3, then 0x0. Undefined -> 0x3, then 0x3.
